// File: rtl/sevenseg_pkg.sv
// Shared segment encodings, BCD-to-segment decode and FSM state type for the
// multi-digit seven-segment driver. Segment order is {g,f,e,d,c,b,a}, active-low.
package sevenseg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_UPDATE = 2'd2
  } state_e;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble core: one add-3/shift step per cycle for IN_W cycles.
// done is high in the cycle whose rising edge performs the final shift.
module bin2bcd_seq #(
  parameter int IN_W   = 16,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin_in,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic                  done
);
  import sevenseg_pkg::*;

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(IN_W + 1);
  localparam logic [CW-1:0] LAST = CW'(IN_W - 1);

  logic [IN_W-1:0] bin_q, bin_d;
  logic [BW-1:0]   bcd_q, bcd_d, adj_s;
  logic            ovf_q, ovf_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            run_q, run_d;

  // Add-3 correction of every nibble before the shift.
  always_comb begin
    adj_s = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      adj_s[4*k +: 4] = (bcd_q[4*k +: 4] >= 4'd5) ? (bcd_q[4*k +: 4] + 4'd3) : bcd_q[4*k +: 4];
    end
  end

  // Load on start, else shift while running; a 1 leaving the top nibble is sticky overflow.
  always_comb begin
    bin_d = bin_q;
    bcd_d = bcd_q;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start) begin
      bin_d = bin_in;
      bcd_d = '0;
      ovf_d = 1'b0;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      bcd_d = {adj_s[BW-2:0], bin_q[IN_W-1]};
      bin_d = {bin_q[IN_W-2:0], 1'b0};
      ovf_d = ovf_q | adj_s[BW-1];
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      run_d = (cnt_q != LAST);
    end else begin
      run_d = 1'b0;
    end
  end

  // Core state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q <= '0;
      bcd_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign bcd      = bcd_q;
  assign overflow = ovf_q;
  assign done     = run_q && (cnt_q == LAST);

endmodule

// File: rtl/multi_sevenseg_display.sv
// Binary-to-seven-segment display driver with a single pending-load slot.
// Define SEVENSEG_LZB_EN to blank leading zero digits (digit 0 is never blanked).
module multi_sevenseg_display #(
  parameter int IN_W   = 16,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IN_W-1:0]       value,
  input  logic                  load,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   seg
);
  import sevenseg_pkg::*;

  state_e state_q, state_d;

  logic                pend_q, pend_d;
  logic [IN_W-1:0]     pend_val_q, pend_val_d;
  logic [7*DIGITS-1:0] seg_q, seg_d, seg_dec_s;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic                busy_q, busy_d;

  logic                core_start_s;
  logic [IN_W-1:0]     core_bin_s;
  logic [4*DIGITS-1:0] core_bcd_s;
  logic                core_ovf_s;
  logic                core_done_s;

  bin2bcd_seq #(
    .IN_W   (IN_W),
    .DIGITS (DIGITS)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (core_start_s),
    .bin_in   (core_bin_s),
    .bcd      (core_bcd_s),
    .overflow (core_ovf_s),
    .done     (core_done_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; UPDATE chains straight into SHIFT when a load is waiting.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = load ? ST_SHIFT : ST_IDLE;
      ST_SHIFT:  state_d = core_done_s ? ST_UPDATE : ST_SHIFT;
      ST_UPDATE: state_d = (load || pend_q) ? ST_SHIFT : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output logic: core start, pending slot and display update.
  always_comb begin
    core_start_s = 1'b0;
    core_bin_s   = value;
    pend_d       = pend_q;
    pend_val_d   = pend_val_q;
    seg_d        = seg_q;
    done_d       = 1'b0;
    ovf_d        = ovf_q;
    case (state_q)
      ST_IDLE: begin
        core_start_s = load;
        pend_d       = 1'b0;
      end
      ST_SHIFT: begin
        if (load) begin
          pend_d     = 1'b1;
          pend_val_d = value;
        end else begin
          pend_d     = pend_q;
        end
      end
      ST_UPDATE: begin
        core_start_s = load || pend_q;
        core_bin_s   = load ? value : pend_val_q;
        pend_d       = 1'b0;
        seg_d        = seg_dec_s;
        done_d       = 1'b1;
        ovf_d        = core_ovf_s;
      end
      default: begin
        pend_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

`ifdef SEVENSEG_LZB_EN
  logic lead_s;
`endif

  // Digit decode from the finished BCD word, scanning from the top digit down.
  always_comb begin
    seg_dec_s = '1;
`ifdef SEVENSEG_LZB_EN
    lead_s = 1'b1;
`endif
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (core_ovf_s) begin
        seg_dec_s[7*k +: 7] = SEG_DASH;
      end
`ifdef SEVENSEG_LZB_EN
      else if (lead_s && (k != 0) && (core_bcd_s[4*k +: 4] == 4'd0)) begin
        seg_dec_s[7*k +: 7] = SEG_BLANK;
      end
`endif
      else begin
        seg_dec_s[7*k +: 7] = bcd_to_seg(core_bcd_s[4*k +: 4]);
      end
`ifdef SEVENSEG_LZB_EN
      lead_s = lead_s && (core_bcd_s[4*k +: 4] == 4'd0);
`endif
    end
  end

  // Display and status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      seg_q      <= '1;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      seg_q      <= seg_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
    end
  end

  assign seg      = seg_q;
  assign done     = done_q;
  assign overflow = ovf_q;
  assign busy     = busy_q;

endmodule
